// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: start/busy/done handshake and data bus of the BCD-to-binary converter.
// The master drives the request (start, bcd_in) and the slave (the converter) returns the result.
interface bcd_to_binary_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) ();

  logic                  start;
  logic [4*DIGITS:0]     bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary_out;
  logic                  sign_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  binary_out,
    input  sign_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output binary_out,
    output sign_out,
    output err
  );

endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential signed-magnitude BCD-to-binary converter (reverse double dabble).
// One shift-right/correct step per clock; IDLE -> SHIFT -> DONE -> IDLE.
// Optional feature macro: BCD_CHECK_EN (flags any input nibble > 9; result forced to 0 with err=1).
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_to_binary_if.slave     bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               step;
  logic               finish;

  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_next;
  logic [CW-1:0]      count;
  logic               sign_q;

  logic [BIN_W-1:0]   binary_q;
  logic               sign_out_q;
  logic               err_q;

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One reverse double-dabble step: shift right, then take 3 off every BCD nibble >= 8
  always_comb begin
    sr_next = sr >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_next[BIN_W + 4*i +: 4] >= 4'd8) begin
        sr_next[BIN_W + 4*i +: 4] = sr_next[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Working shift register, step counter and captured sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      count  <= '0;
      sign_q <= 1'b0;
    end else if (load) begin
      sr     <= {bus.bcd_in[BCD_W-1:0], {BIN_W{1'b0}}};
      count  <= '0;
      sign_q <= bus.bcd_in[BCD_W];
    end else if (step) begin
      sr     <= sr_next;
      count  <= count + CW'(1);
    end
  end

`ifdef BCD_CHECK_EN
  logic invalid;
  logic bad_q;

  // Any nibble above 9 in the request marks the whole conversion as invalid
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) begin
        invalid = 1'b1;
      end
    end
  end

  // Sticky invalid-digit flag for the conversion in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
    end else if (load) begin
      bad_q <= invalid;
    end
  end

  // Result registers, updated only on the final step; invalid input yields zero with err set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_q   <= '0;
      sign_out_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (finish) begin
      binary_q   <= bad_q ? '0 : sr_next[BIN_W-1:0];
      sign_out_q <= sign_q;
      err_q      <= bad_q;
    end
  end
`else
  // Result registers, updated only on the final step and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_q   <= '0;
      sign_out_q <= 1'b0;
    end else if (finish) begin
      binary_q   <= sr_next[BIN_W-1:0];
      sign_out_q <= sign_q;
    end
  end

  assign err_q = 1'b0;
`endif

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.binary_out = binary_q;
  assign bus.sign_out   = sign_out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_bcd_to_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait one idle cycle, then pulse start for exactly one edge; returns #1 after the load edge
  task automatic start_conv(input logic [4*DIGITS:0] value);
    @(posedge clk); #1;
    bus.bcd_in = value;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
  endtask

  // Bounded wait for done; latency counts cycles after the load edge
  task automatic wait_done(output int latency, output bit seen);
    seen    = 1'b0;
    latency = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen    = 1'b1;
        latency = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    #23;
    checks++;
    if ({bus.busy, bus.done, bus.sign_out, bus.err} !== 4'b0000 || bus.binary_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b bin=%h sign=%b err=%b, expected all zero",
               bus.busy, bus.done, bus.binary_out, bus.sign_out, bus.err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_max_timing();
    int busy_cycles;
    bit early_done;
    busy_cycles = 0;
    early_done  = 1'b0;
    start_conv({1'b0, 16'h9999});
    for (int i = 0; i < 16; i++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) early_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cycles != 16 || early_done) begin
      errors++;
      $display("[TB] FAIL max_busy: busy cycles %0d early_done %b, expected 16 and 0", busy_cycles, early_done);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_done_time: done=%b busy=%b at cycle 16, expected 1 and 0", bus.done, bus.busy);
    end
    checks++;
    if (bus.binary_out !== 16'h270F || bus.sign_out !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_value: got %h sign %b err %b, expected 270f 0 0", bus.binary_out, bus.sign_out, bus.err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.binary_out !== 16'h270F) begin
      errors++;
      $display("[TB] FAIL max_done_pulse: done=%b busy=%b bin=%h, expected 0 0 270f", bus.done, bus.busy, bus.binary_out);
    end
  endtask

  task automatic test_sequence();
    int lat;
    bit seen;
    start_conv({1'b0, 16'h1234});
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != 16 || bus.binary_out !== 16'h04D2 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_1234: seen %b lat %0d bin %h sign %b, expected 1 16 04d2 0", seen, lat, bus.binary_out, bus.sign_out);
    end
    start_conv({1'b1, 16'h0042});
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.binary_out !== 16'h04D2 || bus.sign_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_hold: mid-conversion bin %h sign %b, expected 04d2 0", bus.binary_out, bus.sign_out);
    end
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != 8 || bus.binary_out !== 16'h002A || bus.sign_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seq_0042: seen %b lat %0d bin %h sign %b, expected 1 8 002a 1", seen, lat, bus.binary_out, bus.sign_out);
    end
  endtask

  task automatic test_zero();
    logic [4*DIGITS:0] vec [2];
    int dones;
    vec[0] = {1'b0, 16'h0000};
    vec[1] = {1'b1, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      dones = 0;
      start_conv(vec[v]);
      for (int i = 1; i <= 24; i++) begin
        @(posedge clk); #1;
        if (bus.done) dones++;
      end
      checks++;
      if (dones != 1 || bus.binary_out !== 16'h0000 || bus.sign_out !== v[0]) begin
        errors++;
        $display("[TB] FAIL zero_%0d: dones %0d bin %h sign %b, expected 1 0000 %0d", v, dones, bus.binary_out, bus.sign_out, v);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    int first;
    dones = 0;
    first = 0;
    start_conv({1'b0, 16'h0500});
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      bus.start  = (i == 3 || i == 10);
      bus.bcd_in = {1'b1, 16'h0999};
      if (bus.done) begin
        dones++;
        if (first == 0) first = i;
      end
    end
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    checks++;
    if (dones != 1 || first != 16) begin
      errors++;
      $display("[TB] FAIL ignore_start_dones: dones %0d first %0d, expected 1 at 16", dones, first);
    end
    checks++;
    if (bus.binary_out !== 16'h01F4 || bus.sign_out !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_start_value: bin %h sign %b busy %b, expected 01f4 0 0", bus.binary_out, bus.sign_out, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int lat;
    bit seen;
    dones = 0;
    start_conv({1'b1, 16'h9999});
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sign_out, bus.err} !== 4'b0000 || bus.binary_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: busy %b done %b bin %h sign %b err %b, expected all zero",
               bus.busy, bus.done, bus.binary_out, bus.sign_out, bus.err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones != 0 || bus.binary_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_abort: activity cycles %0d bin %h, expected 0 0000", dones, bus.binary_out);
    end
    start_conv({1'b0, 16'h9999});
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != 16 || bus.binary_out !== 16'h270F || bus.sign_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_restart: seen %b lat %0d bin %h sign %b, expected 1 16 270f 0", seen, lat, bus.binary_out, bus.sign_out);
    end
  endtask

  task automatic test_digit_check();
    int lat;
    bit seen;
    start_conv({1'b0, 16'h12A4});
    wait_done(lat, seen);
`ifdef BCD_CHECK_EN
    checks++;
    if (!seen || lat != 16 || bus.err !== 1'b1 || bus.binary_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL check_invalid: seen %b lat %0d err %b bin %h, expected 1 16 1 0000", seen, lat, bus.err, bus.binary_out);
    end
`else
    checks++;
    if (!seen || lat != 16 || bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL check_disabled: seen %b lat %0d err %b, expected 1 16 0", seen, lat, bus.err);
    end
`endif
    start_conv({1'b0, 16'h0010});
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != 16 || bus.err !== 1'b0 || bus.binary_out !== 16'h000A) begin
      errors++;
      $display("[TB] FAIL check_valid: seen %b lat %0d err %b bin %h, expected 1 16 0 000a", seen, lat, bus.err, bus.binary_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_max_timing();
    test_sequence();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_digit_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
